// File: rtl/fifo_mac_pkg.sv
// Shared types and default sizing for the FIFO-fed matrix-vector MAC engine.
package fifo_mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int DEF_NUM_ROWS   = 8;
  localparam int DEF_DEPTH      = 8;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ACC_WIDTH  = 24;

  // One FIFO per matrix row plus the shared vector FIFO.
  function automatic int num_fifos(input int num_rows);
    return num_rows + 1;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// One multiply-accumulate lane: unsigned product, zero-extended, accumulator wraps at ACC_WIDTH.
module mac_unit
  import fifo_mac_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clr,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [ACC_WIDTH-1:0]  o_acc
);

  logic [2*DATA_WIDTH-1:0] w_prod;
  logic [ACC_WIDTH-1:0]    r_acc;

  assign w_prod = (2*DATA_WIDTH)'(i_a) * (2*DATA_WIDTH)'(i_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + ACC_WIDTH'(w_prod);
    end else begin
      r_acc <= r_acc;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/fifo_mac_engine.sv
// Drains NUM_ROWS row FIFOs and one vector FIFO into per-row MACs (C = A*B).
// Build option: define SYSTOLIC_SKEW_EN to stagger row pops and pipe B through a skew chain.
module fifo_mac_engine
  import fifo_mac_pkg::*;
#(
  parameter int  NUM_ROWS   = DEF_NUM_ROWS,
  parameter int  DEPTH      = DEF_DEPTH,
  parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int  ACC_WIDTH  = DEF_ACC_WIDTH,
  localparam int NUM_FIFOS  = num_fifos(NUM_ROWS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [NUM_FIFOS-1:0]            fifo_empty,
  input  logic [NUM_FIFOS*DATA_WIDTH-1:0] fifo_rdata,
  output logic [NUM_FIFOS-1:0]            fifo_ren,
  output logic [NUM_ROWS*ACC_WIDTH-1:0]   result,
  output logic                            busy,
  output logic                            done,
  output logic                            error
);

`ifdef SYSTOLIC_SKEW_EN
  localparam int RUN_LEN = DEPTH + NUM_ROWS - 1;
  localparam bit SKEW    = 1'b1;
`else
  localparam int RUN_LEN = DEPTH;
  localparam bit SKEW    = 1'b0;
`endif
  // DRAIN covers the last accumulate plus the cycle that publishes done.
  localparam int               CNT_W      = $clog2(RUN_LEN + 2);
  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(RUN_LEN - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(RUN_LEN + 1);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [NUM_FIFOS-1:0]  r_req;
  logic [NUM_FIFOS-1:0]  w_req_nxt;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;
  logic                  w_start_acc;
  logic                  w_drain_end;
  logic                  w_uflow;
  logic [DATA_WIDTH-1:0] w_b_head;

  function automatic int pop_offset(input int j);
    return (SKEW && (j < NUM_ROWS)) ? j : 0;
  endfunction

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state; start is only honoured from IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    w_drain_end = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_start_acc = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (r_cnt == RUN_LAST) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (r_cnt == DRAIN_LAST) begin
          w_state_nxt = ST_IDLE;
          w_drain_end = 1'b1;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Pop window decode: FIFO j requests for DEPTH cycles starting at its offset.
  always_comb begin
    w_req_nxt = '0;
    for (int j = 0; j < NUM_FIFOS; j++) begin
      if ((r_state == ST_RUN) && (int'(r_cnt) >= pop_offset(j)) &&
          (int'(r_cnt) < pop_offset(j) + DEPTH)) begin
        w_req_nxt[j] = 1'b1;
      end else begin
        w_req_nxt[j] = 1'b0;
      end
    end
  end

  assign w_uflow  = |(r_req & fifo_empty);
  assign fifo_ren = r_req & ~fifo_empty;

  // Cycle counter, pop requests and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_req   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else if (w_start_acc) begin
      r_cnt   <= '0;
      r_req   <= '0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_cnt   <= (r_state == ST_IDLE) ? r_cnt : r_cnt + CNT_W'(1);
      r_req   <= w_req_nxt;
      r_busy  <= r_busy & ~w_drain_end;
      r_done  <= r_done | w_drain_end;
      r_error <= r_error | w_uflow;
    end
  end

  // An empty vector FIFO contributes a zero operand.
  assign w_b_head = (r_req[NUM_ROWS] && !fifo_empty[NUM_ROWS]) ?
                    fifo_rdata[NUM_ROWS*DATA_WIDTH +: DATA_WIDTH] : '0;

`ifdef SYSTOLIC_SKEW_EN
  logic [DATA_WIDTH-1:0] r_bchain [NUM_ROWS-1];

  // B skew chain: stage s feeds row s+1 one cycle after row s.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_ROWS - 1; s++) begin
        r_bchain[s] <= '0;
      end
    end else begin
      r_bchain[0] <= w_b_head;
      for (int s = 1; s < NUM_ROWS - 1; s++) begin
        r_bchain[s] <= r_bchain[s-1];
      end
    end
  end
`endif

  for (genvar i = 0; i < NUM_ROWS; i++) begin : g_row
    logic [DATA_WIDTH-1:0] w_a;
    logic [DATA_WIDTH-1:0] w_b;
    logic [ACC_WIDTH-1:0]  w_acc;

    assign w_a = fifo_empty[i] ? '0 : fifo_rdata[i*DATA_WIDTH +: DATA_WIDTH];
`ifdef SYSTOLIC_SKEW_EN
    if (i == 0) begin : g_head
      assign w_b = w_b_head;
    end else begin : g_tap
      assign w_b = r_bchain[i-1];
    end
`else
    assign w_b = w_b_head;
`endif

    mac_unit #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (w_start_acc),
      .i_en  (r_req[i]),
      .i_a   (w_a),
      .i_b   (w_b),
      .o_acc (w_acc)
    );

    assign result[i*ACC_WIDTH +: ACC_WIDTH] = w_acc;
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign error = r_error;

endmodule

// File: tb/tb_fifo_mac_engine.sv
// Self-checking bench for fifo_mac_engine: FIFO bank model, matrix-vector reference, timing checks.
`timescale 1ns/1ps
module tb_fifo_mac_engine;

  localparam int NR = 8;
  localparam int DP = 8;
  localparam int DW = 8;
  localparam int AW = 24;
  localparam int NF = NR + 1;
`ifdef SYSTOLIC_SKEW_EN
  localparam int DONE_LAT = DP + NR + 1;
  localparam bit SKEW     = 1'b1;
`else
  localparam int DONE_LAT = DP + 2;
  localparam bit SKEW     = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [NF-1:0] fifo_empty;
  logic [NF-1:0] fifo_ren;
  logic [NF*DW-1:0] fifo_rdata;
  logic [NR*AW-1:0] result;
  logic          busy;
  logic          done;
  logic          error;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // FIFO bank model: rdata shows the head entry, a sampled ren advances the pointer.
  logic [DW-1:0] mem [NF][DP+1];
  int            fill [NF] = '{default: 0};
  int            rptr [NF] = '{default: 0};
  logic [NF-1:0] force_mask = '0;
  int            load_gen = 0;
  int            seen_gen = 0;

  // Per-run observations and reference results.
  int            pops [NF];
  int            first_pop [NF];
  int            done_cyc;
  int            t0;
  logic          snap_busy, snap_done, snap_err;
  logic [NR*AW-1:0] snap_res;
  logic [AW-1:0] exp_res [NR];

  fifo_mac_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_ren   (fifo_ren),
    .result     (result),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (load_gen != seen_gen) begin
      seen_gen <= load_gen;
      for (int j = 0; j < NF; j++) rptr[j] <= 0;
    end else begin
      for (int j = 0; j < NF; j++) if (fifo_ren[j]) rptr[j] <= rptr[j] + 1;
    end
  end

  for (genvar j = 0; j < NF; j++) begin : g_fifo
    assign fifo_empty[j] = force_mask[j] || (rptr[j] >= fill[j]);
    assign fifo_rdata[j*DW +: DW] = (rptr[j] < fill[j]) ? mem[j][rptr[j]] : 8'hA5;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Fill every FIFO with DEPTH entries plus one extra that must never be consumed.
  task automatic load_fifos(input int pattern, input logic [NF-1:0] fmask);
    logic [DW-1:0] v;
    longint acc_l;
    for (int j = 0; j < NF; j++) begin
      for (int k = 0; k < DP; k++) begin
        case (pattern)
          0: v = 8'd1;
          1: v = (j < NR) ? 8'(j + 1) : 8'(k + 1);
          2: v = 8'hFF;
          default: v = 8'($urandom_range(0, 255));
        endcase
        mem[j][k] = v;
      end
      mem[j][DP] = 8'h7F;
      fill[j] = DP + 1;
    end
    force_mask = fmask;
    load_gen = load_gen + 1;
    for (int i = 0; i < NR; i++) begin
      acc_l = 0;
      if (!fmask[i]) begin
        for (int k = 0; k < DP; k++) acc_l += longint'(mem[i][k]) * longint'(mem[NR][k]);
      end
      exp_res[i] = acc_l[AW-1:0];
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  // Pulse start and observe a bounded window; optionally pulse start again at cycle t0+restart_at.
  task automatic run_op(input int restart_at, output bit timed_out);
    for (int j = 0; j < NF; j++) begin
      pops[j] = 0;
      first_pop[j] = -1;
    end
    done_cyc = -1;
    timed_out = 1'b1;
    start = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    snap_busy = busy;
    snap_done = done;
    snap_err  = error;
    snap_res  = result;
    for (int n = 0; n < DONE_LAT + 6; n++) begin
      for (int j = 0; j < NF; j++) begin
        if (fifo_ren[j]) begin
          pops[j]++;
          if (first_pop[j] < 0) first_pop[j] = cyc;
        end
      end
      if (done && done_cyc < 0) begin
        done_cyc = cyc;
        timed_out = 1'b0;
      end
      start = (n == restart_at) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (fifo_ren !== '0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: ren=%b busy=%b done=%b error=%b, required all 0", fifo_ren, busy, done, error);
    end
    n_checks++;
    if (result !== '0) begin
      n_fail++;
      $display("FAIL reset_result: got %h, required 0", result);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_compute(input string name, input int pattern, input logic [NF-1:0] fmask,
                              input int restart_at);
    bit tmo;
    int exp_first;
    load_fifos(pattern, fmask);
    run_op(restart_at, tmo);
    n_checks++;
    if (snap_busy !== 1'b1 || snap_done !== 1'b0 || snap_err !== 1'b0 || snap_res !== '0) begin
      n_fail++;
      $display("FAIL %s start_state: busy=%b done=%b error=%b result=%h, required busy=1 done=0 error=0 result=0",
               name, snap_busy, snap_done, snap_err, snap_res);
    end
    n_checks++;
    if (tmo || done_cyc != t0 + DONE_LAT) begin
      n_fail++;
      $display("FAIL %s done_time: rose at t0+%0d (timeout=%0b), required t0+%0d", name, done_cyc - t0, tmo, DONE_LAT);
    end
    for (int i = 0; i < NR; i++) begin
      n_checks++;
      if (result[i*AW +: AW] !== exp_res[i]) begin
        n_fail++;
        $display("FAIL %s result[%0d]: got %h, required %h", name, i, result[i*AW +: AW], exp_res[i]);
      end
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || error !== (|fmask)) begin
      n_fail++;
      $display("FAIL %s end_flags: done=%b busy=%b error=%b, required done=1 busy=0 error=%b", name, done, busy, error, |fmask);
    end
    for (int j = 0; j < NF; j++) begin
      exp_first = fmask[j] ? -1 : t0 + 1 + ((SKEW && j < NR) ? j : 0);
      n_checks++;
      if (pops[j] != (fmask[j] ? 0 : DP) || first_pop[j] != exp_first) begin
        n_fail++;
        $display("FAIL %s pops[%0d]: count=%0d first=t0+%0d, required count=%0d first=t0+%0d",
                 name, j, pops[j], first_pop[j] - t0, fmask[j] ? 0 : DP, exp_first - t0);
      end
    end
  endtask

  task automatic test_reset_abort;
    int stray;
    load_fifos(0, '0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (fifo_ren !== '0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || result !== '0) begin
      n_fail++;
      $display("FAIL abort_outputs: ren=%b busy=%b done=%b error=%b result=%h, required all 0",
               fifo_ren, busy, done, error, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int n = 0; n < DONE_LAT + 4; n++) begin
      @(negedge clk);
      stray += $countones(fifo_ren);
      stray += (busy === 1'b1 || done === 1'b1) ? 1 : 0;
    end
    n_checks++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL abort_quiet: %0d pop/busy/done observations after reset, required 0", stray);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    test_reset();
    test_compute("ones", 0, '0, -1);
    test_compute("row_scaled", 1, '0, -1);
    test_compute("all_ff", 2, '0, -1);
    test_compute("underflow_row3", 1, 9'h008, -1);
    test_compute("start_mid_run", 0, '0, 3);
    test_compute("start_in_drain", 1, '0, DONE_LAT - 2);
    test_reset_abort();
    test_compute("after_abort", 1, '0, -1);
    for (int r = 0; r < 3; r++) begin
      test_compute("random", 3, '0, -1);
    end
    test_compute("random_underflow", 3, NF'(1) << $urandom_range(0, NR - 1), -1);
    test_compute("back_to_back", 3, '0, -1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
